// File: rtl/conv3x3_window_gen_pkg.sv
// Shared defaults and types for the 3x3 streaming window generator.
// Defaults match the frame geometry used by the MAC layer and multiplier.
package conv3x3_window_gen_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IMG_W_DEF  = 28;
  localparam int unsigned IMG_H_DEF  = 28;
  localparam int unsigned WIN_TAPS   = 9;
  localparam int unsigned WIN_EDGE   = 2;

  typedef enum logic {
    WIN_EMPTY = 1'b0,
    WIN_FULL  = 1'b1
  } win_state_e;

endpackage

// File: rtl/conv3x3_window_gen_line_buf.sv
// Single-port-address line buffer: combinational read of the old word and
// registered write of the new word at the same address in one cycle.
module conv3x3_window_gen_line_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 28,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are never emitted before being rewritten, so no reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 window generator: two line buffers, a 3x3 shift register
// that doubles as the output stage, and a one-deep valid/ready handshake.
module conv3x3_window_gen
  import conv3x3_window_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] d3,
  output logic [DATA_W-1:0] d4,
  output logic [DATA_W-1:0] d5,
  output logic [DATA_W-1:0] d6,
  output logic [DATA_W-1:0] d7,
  output logic [DATA_W-1:0] d8,
  output logic [DATA_W-1:0] d9,
  output logic              frame_done
);

  localparam int unsigned CW  = $clog2(IMG_W);
  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned LBW = 2 * DATA_W;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(WIN_EDGE);
  localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_EDGE);

  win_state_e        state_q, state_d;
  logic              ready_en_q;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] win_q [WIN_TAPS];
  logic [DATA_W-1:0] win_d [WIN_TAPS];
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic              emit;
  logic              last_px;
  logic [LBW-1:0]    lb_rd;
  logic [LBW-1:0]    lb_wr;

  // Both lines share one address, so they live side by side: {lb1, lb0}.
  conv3x3_window_gen_line_buf #(
    .WIDTH (LBW),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col_q),
    .wr_data (lb_wr),
    .rd_data (lb_rd)
  );

  assign lb_wr    = {lb_rd[DATA_W-1:0], in_data};
  assign in_ready = ready_en_q && ((state_q == WIN_EMPTY) || win_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
  assign last_px  = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Next-state: consume clears the window, an emitting accept reloads it.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    frame_done_d = frame_done_q;

    if ((state_q == WIN_FULL) && win_ready) begin
      state_d      = WIN_EMPTY;
      frame_done_d = 1'b0;
    end

    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb_rd[LBW-1:DATA_W];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb_rd[DATA_W-1:0];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_data;

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (emit) begin
        state_d      = WIN_FULL;
        frame_done_d = last_px;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WIN_EMPTY;
      ready_en_q   <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < WIN_TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ready_en_q   <= 1'b1;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign win_valid  = (state_q == WIN_FULL);
  assign frame_done = frame_done_q;
  assign d1 = win_q[0];
  assign d2 = win_q[1];
  assign d3 = win_q[2];
  assign d4 = win_q[3];
  assign d5 = win_q[4];
  assign d6 = win_q[5];
  assign d7 = win_q[6];
  assign d8 = win_q[7];
  assign d9 = win_q[8];

endmodule
